sha_unpadder: RTL and testbench

Inverse of the SHA-256 message preprocessor. Accepts a stream of padded 512-bit blocks, validates the padding byte by byte, and recovers the original message right-aligned in a 1976-bit field with its bit length. The bench uses it as a round-trip checker on preprocessor output, and the miner datapath uses it to sanity-check externally supplied block sets.

---
 rtl/sha_unpadder.sv | 155 +++++++++++++++
 tb/tb_sha_unpadder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha_unpadder.sv
// sha_unpadder: strips and validates SHA-256 padding from up to four
// 512-bit blocks, recovering the message right-aligned with its length.
module sha_unpadder (
  input  logic          clk,
  input  logic          rst,
  input  logic [511:0]  block_in,
  input  logic          block_valid,
  input  logic          block_last,
  output logic          block_ready,
  output logic [1975:0] msgOut,
  output logic [63:0]   msgLength,
  output logic          error,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SCAN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [2047:0]   r_buf;
  logic [2:0]      r_nblk;
  logic [63:0]     r_len;
  logic [8:0]      r_k;
  logic [8:0]      r_idx;
  logic [1975:0]   r_msg;
  logic [63:0]     r_mlen;
  logic            r_err;
  logic            r_done;

  logic [63:0]     w_len;
  logic [63:0]     w_cap;
  logic [63:0]     w_cap_prev;
  logic [63:0]     w_l65;
  logic            w_bad;
  logic [11:0]     w_diff;
  logic [8:0]      w_k;
  logic [7:0]      w_byte;
  logic            w_last;
  logic [7:0]      w_exp;
  logic            w_ok;
  logic [1975:0]   w_msg_next;

  assign w_len      = r_buf[63:0];
  assign w_cap      = {52'b0, r_nblk, 9'b0};
  assign w_cap_prev = w_cap - 64'd512;
  assign w_l65      = w_len + 64'd65;

  // length must be byte aligned, fit the buffer and need exactly nblk blocks
  assign w_bad = (w_len[2:0] != 3'd0)
              || (w_len > 64'd1976)
              || (w_l65 > w_cap)
              || (w_l65 <= w_cap_prev);

  assign w_diff     = w_cap[11:0] - w_len[11:0];
  assign w_k        = 9'(w_diff >> 3);
  assign w_byte     = r_buf[7:0];
  assign w_last     = (r_idx == (r_k - 9'd1));
  assign w_exp      = w_last ? 8'h80 : 8'h00;
  assign w_ok       = (r_idx < 9'd8) || (w_byte == w_exp);
  assign w_msg_next = r_buf[1983:8];

  assign block_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign msgOut      = r_msg;
  assign msgLength   = r_mlen;
  assign error       = r_err;
  assign done        = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_nblk  <= '0;
      r_len   <= '0;
      r_k     <= '0;
      r_idx   <= '0;
      r_msg   <= '0;
      r_mlen  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (block_valid) begin
            r_buf   <= {1536'b0, block_in};
            r_nblk  <= 3'd1;
            r_err   <= 1'b0;
            r_state <= block_last ? S_CHECK : S_LOAD;
          end
        end
        S_LOAD: begin
          if (block_valid) begin
            r_buf  <= {r_buf[1535:0], block_in};
            r_nblk <= r_nblk + 3'd1;
            if (block_last) begin
              r_state <= S_CHECK;
            end else if (r_nblk == 3'd3) begin
              r_err   <= 1'b1;
              r_msg   <= '0;
              r_mlen  <= '0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_CHECK: begin
          r_len <= w_len;
          if (w_bad) begin
            r_err   <= 1'b1;
            r_msg   <= '0;
            r_mlen  <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k     <= w_k;
            r_idx   <= '0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (!w_ok) begin
            r_err   <= 1'b1;
            r_msg   <= '0;
            r_mlen  <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_buf <= r_buf >> 8;
            r_idx <= r_idx + 9'd1;
            // marker accepted: message now sits at the bottom of the buffer
            if (w_last) begin
              r_msg   <= w_msg_next;
              r_mlen  <= r_len;
              r_err   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_unpadder.sv
// tb_sha_unpadder: table-driven round-trip checks of sha_unpadder against
// a reference SHA-256 padding model, plus reset-mid-scan sequence.
module tb_sha_unpadder;

  logic          clk;
  logic          rst;
  logic [511:0]  block_in;
  logic          block_valid;
  logic          block_last;
  logic          block_ready;
  logic [1975:0] msgOut;
  logic [63:0]   msgLength;
  logic          error;
  logic          done;

  int n_checks;
  int n_errors;

  sha_unpadder dut (
    .clk         (clk),
    .rst         (rst),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_last  (block_last),
    .block_ready (block_ready),
    .msgOut      (msgOut),
    .msgLength   (msgLength),
    .error       (error),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            len;
    logic [1975:0] msg;
    int            nsend;
    bit            lastf;
    logic [2047:0] flip;
    bit            eerr;
    int            elat;
  } vec_t;

  vec_t          vt[14];
  logic [1975:0] pat;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_msg(input string nm, input logic [1975:0] act,
                         input logic [1975:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got low bits %0h expected low bits %0h",
               nm, act[127:0], exp[127:0]);
    end
  endtask

  // Reference preprocessor: msg || 1 || 0s || L64 over n blocks
  function automatic logic [2047:0] build(input logic [1975:0] m,
                                          input int L, input int n);
    logic [2047:0] p;
    int            sh;
    sh = 512 * n - L;
    p  = {72'b0, m} << sh;
    p  = p | ((2048'b1) << (sh - 1));
    p  = p | {1984'b0, 64'(L)};
    return p;
  endfunction

  function automatic logic [1975:0] trunc(input logic [1975:0] p,
                                          input int L);
    logic [1975:0] r;
    r = p;
    for (int i = L; i < 1976; i++) r[i] = 1'b0;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input int len,
                              input logic [1975:0] msg, input int nsend,
                              input bit lastf, input logic [2047:0] flip,
                              input bit eerr, input int elat);
    vec_t v;
    v.name  = nm;
    v.len   = len;
    v.msg   = msg;
    v.nsend = nsend;
    v.lastf = lastf;
    v.flip  = flip;
    v.eerr  = eerr;
    v.elat  = elat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [2047:0] padded;
    int            lat;
    padded = build(v.msg, v.len, v.nsend) ^ v.flip;
    for (int i = 0; i < v.nsend; i++) begin
      @(negedge clk);
      block_in    = padded[512 * (v.nsend - 1 - i) +: 512];
      block_valid = 1'b1;
      block_last  = v.lastf && (i == v.nsend - 1);
      @(posedge clk);
      #1;
      if (i == 0) chk({v.name, " err_clr"}, 64'(error), 64'd0);
    end
    // garbage offered while busy must be ignored
    block_in    = {16{32'hDEAD_BEEF}};
    block_valid = 1'b1;
    block_last  = 1'b1;
    lat = -1;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(posedge clk);
      @(negedge clk);
      if (c == 0) chk({v.name, " busy"}, 64'(block_ready), 64'd0);
      if (done) begin
        lat = c;
        break;
      end
    end
    block_valid = 1'b0;
    block_last  = 1'b0;
    chk({v.name, " lat"}, 64'(lat), 64'(v.elat));
    chk({v.name, " err"}, 64'(error), 64'(v.eerr));
    chk({v.name, " len"}, msgLength, v.eerr ? 64'd0 : 64'(v.len));
    chk_msg({v.name, " msg"}, msgOut, v.eerr ? 1976'b0 : v.msg);
    @(posedge clk);
    @(negedge clk);
    chk({v.name, " pulse"}, 64'(done), 64'd0);
    chk({v.name, " rdy"}, 64'(block_ready), 64'd1);
  endtask

  initial begin
    logic [2047:0] f_mark;
    logic [2047:0] f_zero;
    logic [2047:0] nof;
    logic [2047:0] padded;
    int            npulse;

    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    block_in    = '0;
    block_valid = 1'b0;
    block_last  = 1'b0;

    for (int i = 0; i < 61; i++)
      pat[32 * i +: 32] = 32'(32'h9E37_79B9 * (i + 1));
    pat[1975:1952] = 24'hABCDEF;

    nof            = '0;
    f_mark         = '0;
    f_mark[487:480] = 8'hC0;
    f_zero         = '0;
    f_zero[167:160] = 8'h01;

    vt[0]  = mk("empty", 0, '0, 1, 1, nof, 0, 65);
    vt[1]  = mk("abc", 24, 1976'h616263, 1, 1, nof, 0, 62);
    vt[2]  = mk("L8", 8, 1976'h5A, 1, 1, nof, 0, 64);
    vt[3]  = mk("L440", 440, trunc(pat, 440), 1, 1, nof, 0, 10);
    vt[4]  = mk("L448", 448, trunc(pat, 448), 2, 1, nof, 0, 73);
    vt[5]  = mk("L456", 456, trunc(pat, 456), 2, 1, nof, 0, 72);
    vt[6]  = mk("L1976", 1976, pat, 4, 1, nof, 0, 10);
    vt[7]  = mk("marker", 24, 1976'h616263, 1, 1, f_mark, 1, 62);
    vt[8]  = mk("zero20", 24, 1976'h616263, 1, 1, f_zero, 1, 22);
    vt[9]  = mk("L24x2", 24, 1976'h616263, 2, 1, nof, 1, 1);
    vt[10] = mk("odd23", 23, 1976'h30B131, 1, 1, nof, 1, 1);
    vt[11] = mk("ovfl", 24, 1976'h616263, 4, 0, nof, 1, 0);
    vt[12] = mk("L1984", 1984, '0, 4, 1, nof, 1, 1);
    vt[13] = mk("abc2", 24, 1976'h616263, 1, 1, nof, 0, 62);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ready", 64'(block_ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst error", 64'(error), 64'd0);
    chk("rst len", msgLength, 64'd0);
    chk_msg("rst msg", msgOut, '0);
    rst = 1'b0;

    foreach (vt[i]) run_vec(vt[i]);

    // Reset in the middle of a scan discards the message silently
    padded = build(1976'h616263, 24, 1);
    @(negedge clk);
    block_in    = padded[511:0];
    block_valid = 1'b1;
    block_last  = 1'b1;
    @(posedge clk);
    #1;
    block_valid = 1'b0;
    block_last  = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst done", 64'(done), 64'd0);
    chk("mid rst error", 64'(error), 64'd0);
    chk("mid rst len", msgLength, 64'd0);
    chk_msg("mid rst msg", msgOut, '0);
    chk("mid rst ready", 64'(block_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    npulse = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) npulse++;
    end
    chk("mid rst no done", 64'(npulse), 64'd0);
    chk("mid rst len hold", msgLength, 64'd0);

    run_vec(vt[6]);
    run_vec(vt[1]);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
